// File: rtl/stream_utils_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_utils_pkg
//  Description : Shared definitions for the throttled stream blocks:
//                sink FSM state encoding, LFSR seed/polynomial constants
//                and the LFSR step/seed helper functions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_utils_pkg;

    // Sink FSM state encoding
    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_READ = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FIN  = 2'd2;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] c_LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_TAPS         = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero seed would lock the LFSR up, so it is replaced
    function automatic logic [15:0] lfsr_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? c_LFSR_DEFAULT_SEED : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_lfsr
//  Description : Free-running 16-bit Galois LFSR, advances every cycle.
//                Shared by throttled sinks and sources.
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset (loads seed)
//                state_o - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_lfsr
    import stream_utils_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    localparam logic [15:0] c_SEED_EFF = lfsr_seed(SEED);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_SEED_EFF;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: rtl/stream_throttled_sink.sv
`default_nettype none
// ============================================================================
//  Module      : stream_throttled_sink
//  Description : Valid/ready stream sink that reads blocks of a requested
//                length with pseudo-random back-pressure, an optional
//                incrementing-pattern data check and an inactivity timeout.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                stream_s_*            - sink side of the stream
//                cfg_rate_i            - ready probability (1/256 steps)
//                start_i, length_i,
//                timeout_i             - block request and its parameters
//                chk_en_i, chk_base_i  - pattern check enable / first word
//                busy_o, done_o        - block status
//                err_timeout_o         - sticky timeout flag
//                word_o/_valid_o/_idx_o- copy of each accepted word
//                mismatch_cnt_o        - saturating check failure count
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_throttled_sink
    import stream_utils_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          LEN_W = 16,
    parameter int          TO_W  = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] stream_s_data_i,
    input  logic             stream_s_valid_i,
    output logic             stream_s_ready_o,
    input  logic [7:0]       cfg_rate_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [TO_W-1:0]  timeout_i,
    input  logic             chk_en_i,
    input  logic [WIDTH-1:0] chk_base_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_timeout_o,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    output logic [LEN_W-1:0] word_idx_o,
    output logic [LEN_W-1:0] mismatch_cnt_o
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;

    logic             r_ready;
    logic [LEN_W-1:0] r_len;
    logic [TO_W-1:0]  r_tmo;
    logic [LEN_W-1:0] r_idx;
    logic [TO_W-1:0]  r_to_cnt;
    logic [WIDTH-1:0] r_expect;
    logic [LEN_W-1:0] r_mism;
    logic             r_err;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic [LEN_W-1:0] r_word_idx;

    logic [15:0]      w_lfsr;
    logic             w_lfsr_unused;
    logic             w_xfer;
    logic             w_start_ok;
    logic             w_last;
    logic [TO_W-1:0]  w_to_cnt_inc;
    logic             w_timeout;
    logic             w_ready_roll;

    stream_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (w_lfsr)
    );

    // Only the low byte drives the throttle decision
    assign w_lfsr_unused = ^w_lfsr[15:8];

    assign w_xfer       = stream_s_valid_i & r_ready;
    assign w_start_ok   = (r_state == c_ST_IDLE) & start_i;
    assign w_last       = w_xfer & (r_idx == (r_len - LEN_W'(1)));
    // Counter value including the current READ cycle, so a timeout of N
    // ends the block after exactly N idle READ cycles.
    assign w_to_cnt_inc = r_to_cnt + TO_W'(1);
    assign w_timeout    = (r_tmo != '0) & (w_to_cnt_inc == r_tmo) & ~w_xfer;
    assign w_ready_roll = (w_lfsr[7:0] < cfg_rate_i) | (cfg_rate_i == 8'hFF);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_state_next = (length_i != '0) ? c_ST_READ : c_ST_FIN;
                end
            end
            c_ST_READ: begin
                // A transfer on the last word beats a coincident timeout
                if (w_last || w_timeout) begin
                    w_state_next = c_ST_FIN;
                end
            end
            c_ST_FIN:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state != c_ST_IDLE);
        done_o = (r_state == c_ST_FIN);
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_len        <= '0;
            r_tmo        <= '0;
            r_idx        <= '0;
            r_to_cnt     <= '0;
            r_expect     <= '0;
            r_mism       <= '0;
            r_err        <= 1'b0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_word_idx   <= '0;
        end else begin
            r_word_valid <= 1'b0;
            // Ready looks one state ahead so it falls on the edge that
            // accepts the last word or hits the timeout.
            r_ready      <= (w_state_next == c_ST_READ) & w_ready_roll;

            if (w_start_ok) begin
                r_len    <= length_i;
                r_tmo    <= timeout_i;
                r_idx    <= '0;
                r_to_cnt <= '0;
                r_expect <= chk_base_i;
                r_mism   <= '0;
                r_err    <= 1'b0;
            end else if (r_state == c_ST_READ) begin
                if (w_xfer) begin
                    r_word       <= stream_s_data_i;
                    r_word_valid <= 1'b1;
                    r_word_idx   <= r_idx;
                    r_idx        <= r_idx + LEN_W'(1);
                    r_to_cnt     <= '0;
                    r_expect     <= r_expect + WIDTH'(1);
                    if (chk_en_i && (stream_s_data_i != r_expect) && (r_mism != '1)) begin
                        r_mism <= r_mism + LEN_W'(1);
                    end
                end else begin
                    r_to_cnt <= w_to_cnt_inc;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign stream_s_ready_o = r_ready;
    assign err_timeout_o    = r_err;
    assign word_o           = r_word;
    assign word_valid_o     = r_word_valid;
    assign word_idx_o       = r_word_idx;
    assign mismatch_cnt_o   = r_mism;

endmodule
`default_nettype wire

// File: tb/tb_stream_throttled_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_throttled_sink
//  Description : Self-checking bench for stream_throttled_sink. A vector
//                table describes whole blocks; a stream source model pushes
//                every word it hands over into a scoreboard that is popped
//                when the sink echoes the word on word_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_throttled_sink;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;
    localparam int TO_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] stream_s_data_i = '0;
    logic             stream_s_valid_i = 1'b0;
    logic             stream_s_ready_o;
    logic [7:0]       cfg_rate_i = '0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] length_i = '0;
    logic [TO_W-1:0]  timeout_i = '0;
    logic             chk_en_i = 1'b0;
    logic [WIDTH-1:0] chk_base_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             err_timeout_o;
    logic [WIDTH-1:0] word_o;
    logic             word_valid_o;
    logic [LEN_W-1:0] word_idx_o;
    logic [LEN_W-1:0] mismatch_cnt_o;

    stream_throttled_sink #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .TO_W  (TO_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_s_data_i  (stream_s_data_i),
        .stream_s_valid_i (stream_s_valid_i),
        .stream_s_ready_o (stream_s_ready_o),
        .cfg_rate_i       (cfg_rate_i),
        .start_i          (start_i),
        .length_i         (length_i),
        .timeout_i        (timeout_i),
        .chk_en_i         (chk_en_i),
        .chk_base_i       (chk_base_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_timeout_o    (err_timeout_o),
        .word_o           (word_o),
        .word_valid_o     (word_valid_o),
        .word_idx_o       (word_idx_o),
        .mismatch_cnt_o   (mismatch_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rate;
        int          len;
        int          tmo;
        bit          chk_en;
        logic [31:0] base;
        logic [31:0] dstart;    // source sends dstart + i ...
        int          bad_idx;   // ... except word bad_idx, which is bad_val
        logic [31:0] bad_val;
        bit          valid_on;
        int          exp_xfers;
        int          exp_mism;
        bit          exp_err;
        int          exp_lat;   // edges from start edge to done, -1 = skip
        int          exp_rdy;   // ready cycles while reading, -1 = skip
        bit          chk_duty;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          idx;
    } sb_t;

    sb_t         sbq[$];
    sb_t         sb_e;
    int          checks = 0;
    int          errors = 0;

    // source model state
    int          src_idx = 0;
    int          src_avail = 0;
    int          n_xfers = 0;
    logic [31:0] src_dstart = '0;
    int          src_bad_idx = -1;
    logic [31:0] src_bad_val = '0;
    bit          armed = 1'b0;

    // observation counters
    int          rdy_cycles = 0;
    int          read_cycles = 0;
    int          rdy_viol = 0;
    int          done_viol = 0;
    bit          done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_word(input int i);
        return (i == src_bad_idx) ? src_bad_val : src_dstart + 32'(i);
    endfunction

    // Monitor + source, both away from the active edge
    always @(negedge clk) begin
        if (word_valid_o) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h idx %0d expected none", word_o, word_idx_o);
            end else begin
                sb_e = sbq.pop_front();
                chk("word_data", 64'(word_o), 64'(sb_e.data));
                chk("word_idx", 64'(word_idx_o), 64'(sb_e.idx));
            end
        end
        if (stream_s_ready_o && (!busy_o || done_o)) rdy_viol++;
        if (busy_o && !done_o) begin
            read_cycles++;
            if (stream_s_ready_o) rdy_cycles++;
        end
        if (done_o && done_prev) done_viol++;
        done_prev = done_o;

        if (armed) begin
            src_idx++;
            n_xfers++;
        end
        if (src_idx < src_avail) begin
            stream_s_valid_i = 1'b1;
            stream_s_data_i  = src_word(src_idx);
        end else begin
            stream_s_valid_i = 1'b0;
            stream_s_data_i  = '0;
        end
        armed = stream_s_valid_i && stream_s_ready_o;
        if (armed) sbq.push_back('{src_word(src_idx), src_idx});
    end

    task automatic setup_block(input vec_t v);
        src_dstart  = v.dstart;
        src_bad_idx = v.bad_idx;
        src_bad_val = v.bad_val;
        src_idx     = 0;
        n_xfers     = 0;
        // extra words available so an over-read would be caught
        src_avail   = v.valid_on ? v.len + 4 : 0;
        cfg_rate_i  = v.rate;
        length_i    = LEN_W'(v.len);
        timeout_i   = TO_W'(v.tmo);
        chk_en_i    = v.chk_en;
        chk_base_i  = v.base;
        start_i     = 1'b1;
        rdy_cycles  = 0;
        read_cycles = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(posedge clk); #1;
        setup_block(v);
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done expected done within 3000 cycles");
            return;
        end
        if (v.exp_lat >= 0) chk("done_latency", 64'(lat), 64'(v.exp_lat));
        chk("mismatch_cnt", 64'(mismatch_cnt_o), 64'(v.exp_mism));
        chk("err_timeout", 64'(err_timeout_o), 64'(v.exp_err));
        @(posedge clk); #1;
        chk("busy_after_done", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("xfer_count", 64'(n_xfers), 64'(v.exp_xfers));
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        if (v.exp_rdy >= 0) chk("ready_cycles", 64'(rdy_cycles), 64'(v.exp_rdy));
        if (v.chk_duty) begin
            int pct;
            pct = (read_cycles > 0) ? (rdy_cycles * 100) / read_cycles : 0;
            chk("ready_duty_40_60", 64'((pct >= 40) && (pct <= 60)), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        //             rate   len tmo chk base   dstart bad bad_v vld xf mis err lat rdy duty
        vecs[0] = '{8'hFF,   4,  0, 1, 32'h10, 32'h10, -1, 0,   1,  4, 0, 0,  4,  4, 0};
        vecs[1] = '{8'hFF,   0,  0, 1, 32'h0,  32'h0,  -1, 0,   1,  0, 0, 0,  0,  0, 0};
        vecs[2] = '{8'hFF,   4, 10, 0, 32'h0,  32'h0,  -1, 0,   0,  0, 0, 1, 10, 10, 0};
        vecs[3] = '{8'hFF,   4,  0, 1, 32'h0,  32'h0,   2, 5,   1,  4, 1, 0,  4,  4, 0};
        vecs[4] = '{8'h80,  64,  0, 0, 32'h0,  32'h0,  -1, 0,   1, 64, 0, 0, -1, 64, 1};
        vecs[5] = '{8'h40,   8,  0, 1, 32'h0,  32'd100,-1, 0,   1,  8, 8, 0, -1,  8, 0};
        vecs[6] = '{8'h40,   8,  0, 0, 32'h0,  32'd100,-1, 0,   1,  8, 0, 0, -1,  8, 0};
        vecs[7] = '{8'h00,   5,  3, 0, 32'h0,  32'h0,  -1, 0,   1,  0, 0, 1,  3,  0, 0};
        vecs[8] = '{8'hFF,   4,  1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, -1, 0, 1, 4, 0, 0, 4, 4, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(stream_s_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_timeout_o), 64'd0);
        chk("rst_word_valid", 64'(word_valid_o), 64'd0);
        chk("rst_word", 64'(word_o), 64'd0);
        chk("rst_mismatch", 64'(mismatch_cnt_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy_o), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // reset in the middle of an 8-word block
        v = '{8'hFF, 8, 0, 0, 32'h0, 32'h200, -1, 0, 1, 0, 0, 0, -1, -1, 0};
        @(posedge clk); #1;
        setup_block(v);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        chk("pre_rst_word_valid", 64'(word_valid_o), 64'd1);
        chk("pre_rst_ready", 64'(stream_s_ready_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(stream_s_ready_o), 64'd0);
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_word_valid", 64'(word_valid_o), 64'd0);
        chk("async_rst_idx", 64'(word_idx_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_in_rst", 64'(done_o), 64'd0);
        end
        @(posedge clk); #1;
        chk("xfers_before_rst", 64'(n_xfers), 64'd3);
        sbq.delete();
        src_avail = 0;
        rst_n = 1'b1;
        v = '{8'hFF, 2, 0, 1, 32'h7, 32'h7, -1, 0, 1, 2, 0, 0, 2, 2, 0};
        run_vec(v);

        chk("ready_only_in_read", 64'(rdy_viol), 64'd0);
        chk("done_single_cycle", 64'(done_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_throttled_sink.md
STREAM_THROTTLED_SINK -- requirements
Module: stream_throttled_sink

Interface
REQ-001 Parameter WIDTH, default 32, stream data width in bits (>=1).
REQ-002 Parameter LEN_W, default 16, width of block length, word index and mismatch counter.
REQ-003 Parameter TO_W, default 16, width of timeout value and cycle counter.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset seed; 0 SHALL be replaced by 16'hACE1.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 stream_s_data_i  input  WIDTH  sink data.
REQ-008 stream_s_valid_i  input  1  source has data.
REQ-009 stream_s_ready_o  output  1  registered sink ready.
REQ-010 cfg_rate_i  input  8  ready probability in 1/256 steps; 8'hFF = always ready.
REQ-011 start_i  input  1  one-cycle request to read a block.
REQ-012 length_i  input  LEN_W  block length in words, sampled on accepted start.
REQ-013 timeout_i  input  TO_W  max cycles between transfers, sampled on start; 0 disables.
REQ-014 chk_en_i / chk_base_i  input  1 / WIDTH  enable incrementing-pattern check, first expected word.
REQ-015 busy_o  output  1  block in progress.
REQ-016 done_o  output  1  one-cycle pulse at block end (normal or timeout).
REQ-017 err_timeout_o  output  1  sticky timeout flag.
REQ-018 word_o / word_valid_o / word_idx_o  output  WIDTH / 1 / LEN_W  registered copy of accepted word, one-cycle valid, its index.
REQ-019 mismatch_cnt_o  output  LEN_W  saturating count of check failures in current block.

Function
REQ-020 Transfer SHALL occur on a rising edge where stream_s_valid_i and stream_s_ready_o are both 1.
REQ-021 FSM states SHALL be IDLE, READ, FIN; reset state IDLE.
REQ-022 IDLE: start_i with length_i>0 -> READ; with length_i==0 -> FIN; start_i ignored in READ and FIN.
REQ-023 Accepted start SHALL clear err_timeout_o, mismatch_cnt_o, word index and timeout counter, and load expected word = chk_base_i.
REQ-024 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle in every state.
REQ-025 In READ, next stream_s_ready_o = (lfsr[7:0] < cfg_rate_i) or (cfg_rate_i==8'hFF); cfg_rate_i=0 holds ready low.
REQ-026 stream_s_ready_o SHALL be 0 outside READ and SHALL drop to 0 on the edge accepting the last word (no extra transfer).
REQ-027 Each transfer SHALL register data into word_o, pulse word_valid_o next cycle with word_idx_o = index, then increment index.
REQ-028 With chk_en_i=1, a transfer whose data differs from expected SHALL increment mismatch_cnt_o (saturating at all-ones); expected SHALL increment by 1 modulo 2^WIDTH per transfer regardless of match.
REQ-029 Transfer with index==length-1 -> FIN.
REQ-030 Timeout counter SHALL count READ cycles since start or last transfer, reset on each transfer; when timeout_i!=0 and counter==timeout_i with no transfer that cycle -> FIN with err_timeout_o=1.
REQ-031 FIN SHALL last one cycle, assert done_o, then -> IDLE; busy_o=1 in READ and FIN.
REQ-032 Transfer and timeout in same cycle: transfer wins, counter reset.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, all outputs 0, counters 0, LFSR = SEED (or 16'hACE1).
REQ-034 Reset mid-block SHALL abandon the block without done_o; first start after release SHALL behave as from power-up.

Structure
REQ-035 FSM state encoding and the default LFSR seed/polynomial constants SHALL live in shared package stream_utils_pkg.
REQ-036 LFSR SHALL be a sub-module stream_lfsr (parameter SEED, output 16-bit state), reusable by a throttled source.

Verification
REQ-037 rate=8'hFF, length=4, valid always 1, data 0x10..0x13, chk_base=0x10 -> ready high 4 cycles, 4 transfers, done_o at cycle after last, mismatch_cnt=0.
REQ-038 rate=0x80, length=64, continuous valid -> exactly 64 transfers, ready duty within 40-60 %, word_idx_o 0..63 in order.
REQ-039 rate=8'hFF, timeout=10, valid held 0 -> done_o and err_timeout_o=1 exactly 10 cycles after start's READ entry, no transfers.
REQ-040 length=0 -> done_o one cycle after start, ready never asserted.
REQ-041 chk_en=1, base=0, data 0,1,5,3 -> mismatch_cnt_o=1 at done.
REQ-042 rst_n asserted at transfer 3 of 8 -> ready, busy, word_valid_o drop asynchronously, no done_o; new start of length 2 completes normally.
